// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: control-field layout, ALU/funct codes,
// multiply/divide op codes and the multiply/divide sequencer states.
package cpu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int EX_ALU_SRC    = 0;
  localparam int EX_ALU_OP_LSB = 1;
  localparam int EX_REG_DST    = 3;
  localparam int EX_MD_LSB     = 4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Ops that occupy the iterative unit for N cycles.
  function automatic logic md_is_iter(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Signed ops run on magnitudes; the sign fix-up is applied when HI/LO are written.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    md_op,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int N  = DW / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  md_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic          fresh;
  logic          start, last;

  logic          signed_op, op_div, sign_a, sign_b;
  logic [DW-1:0] mag_a, mag_b;

  logic [DW:0]   acc_hi;
  logic [DW-1:0] acc_lo, opb;
  logic          is_div, neg_q, neg_r, div0;

  logic [DW:0]     w_hi, r_try;
  logic [DW-1:0]   w_lo;
  logic [2*DW-1:0] prod, prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix;

  // The cycle right after reset never starts an op, so stall is guaranteed low there.
  always_comb begin : fsm_next
    state_n = state;
    stall   = 1'b0;
    done    = 1'b0;
    start   = md_is_iter(md_op) && !fresh;
    last    = (cnt == LAST);
    case (state)
      MD_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_n = MD_BUSY;
        end
      end
      MD_BUSY: begin
        stall = 1'b1;
        if (last) state_n = MD_DONE;
      end
      MD_DONE: begin
        done    = 1'b1;
        state_n = MD_IDLE;
      end
      default: state_n = MD_IDLE;
    endcase
  end

  always_comb begin : operand_cond
    signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    op_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
    sign_a    = signed_op && rs_val[DW-1];
    sign_b    = signed_op && rt_val[DW-1];
    mag_a     = sign_a ? (DW'(0) - rs_val) : rs_val;
    mag_b     = sign_b ? (DW'(0) - rt_val) : rt_val;
  end

  // RADIX_BITS elementary steps per cycle; acc_hi holds partial product or remainder.
  always_comb begin : iter_step
    w_hi  = acc_hi;
    w_lo  = acc_lo;
    r_try = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (is_div) begin
        r_try = {w_hi[DW-1:0], w_lo[DW-1]};
        w_lo  = {w_lo[DW-2:0], 1'b0};
        if (r_try >= {1'b0, opb}) begin
          r_try   = r_try - {1'b0, opb};
          w_lo[0] = 1'b1;
        end
        w_hi = r_try;
      end else begin
        r_try = w_lo[0] ? (w_hi + {1'b0, opb}) : w_hi;
        {w_hi, w_lo} = {1'b0, r_try, w_lo[DW-1:1]};
      end
    end
  end

  // Divide by zero leaves the dividend in the remainder, so only the quotient needs forcing.
  always_comb begin : sign_fixup
    prod     = {w_hi[DW-1:0], w_lo};
    prod_fix = neg_q ? ((2*DW)'(0) - prod) : prod;
    quo_fix  = div0 ? '1 : (neg_q ? (DW'(0) - w_lo) : w_lo);
    rem_fix  = neg_r ? (DW'(0) - w_hi[DW-1:0]) : w_hi[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      fresh <= 1'b1;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      fresh <= 1'b0;
      if (state == MD_BUSY) cnt <= cnt + 1'b1;
      else                  cnt <= '0;
      if (state == MD_BUSY && last) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else if (state == MD_IDLE) begin
        if (md_op == MD_MTHI) hi <= rs_val;
        if (md_op == MD_MTLO) lo <= rs_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      acc_hi <= '0;
      acc_lo <= mag_a;
      opb    <= mag_b;
      is_div <= op_div;
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      div0   <= op_div && (rt_val == '0);
    end else if (state == MD_BUSY) begin
      acc_hi <= w_hi;
      acc_lo <= w_lo;
    end
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU, branch-target adder, destination mux, the
// iterative multiply/divide unit and the EX/MEM pipeline register.
module ex_muldiv_stage
  import cpu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    wb_ctl_in,
  input  logic [2:0]    m_ctl_in,
  input  logic [7:0]    ex_ctl_in,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] rdata1_in,
  input  logic [DW-1:0] rdata2_in,
  input  logic [DW-1:0] sext_in,
  input  logic [4:0]    rt_in,
  input  logic [4:0]    rd_in,
  output logic          stall,
  output logic [1:0]    wb_ctlout,
  output logic [2:0]    m_ctlout,
  output logic [DW-1:0] alu_result,
  output logic          zero,
  output logic [DW-1:0] branch_target,
  output logic [DW-1:0] store_data,
  output logic [4:0]    wreg
);

  function automatic logic [DW-1:0] alu_eval(
    input logic [1:0]           op,
    input logic [5:0]           funct,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic [DW-1:0] r;
    r = '0;
    case (op)
      ALU_OP_ADD: r = a + b;
      ALU_OP_SUB: r = a - b;
      ALU_OP_OR:  r = a | b;
      default: begin
        case (funct)
          FN_ADD, FN_ADDU: r = a + b;
          FN_SUB, FN_SUBU: r = a - b;
          FN_AND:          r = a & b;
          FN_OR:           r = a | b;
          FN_SLT:          r = (a < b) ? DW'(1) : '0;
          FN_SLTU:         r = ($unsigned(a) < $unsigned(b)) ? DW'(1) : '0;
          default:         r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  logic                 alu_src, reg_dst, md_done;
  logic [1:0]           alu_op;
  logic [3:0]           md_op;
  logic signed [DW-1:0] opa_p0, opb_p0;
  logic [DW-1:0]        alu_out_p0, result_p0, hi, lo;
  logic [1:0]           wb_p0;
  logic [2:0]           m_p0;

  assign alu_src = ex_ctl_in[EX_ALU_SRC];
  assign alu_op  = ex_ctl_in[EX_ALU_OP_LSB +: 2];
  assign reg_dst = ex_ctl_in[EX_REG_DST];
  assign md_op   = ex_ctl_in[EX_MD_LSB +: 4];

  muldiv_unit #(
    .DW         (DW),
    .RADIX_BITS (RADIX_BITS)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .md_op  (md_op),
    .rs_val (rdata1_in),
    .rt_val (rdata2_in),
    .stall  (stall),
    .done   (md_done),
    .hi     (hi),
    .lo     (lo)
  );

  // A multiply/divide retiring in DONE, and mthi/mtlo, write no GPR and touch no memory.
  always_comb begin
    opa_p0     = rdata1_in;
    opb_p0     = alu_src ? sext_in : rdata2_in;
    alu_out_p0 = alu_eval(alu_op, sext_in[5:0], opa_p0, opb_p0);
    case (md_op)
      MD_MFHI: result_p0 = hi;
      MD_MFLO: result_p0 = lo;
      default: result_p0 = alu_out_p0;
    endcase
    wb_p0 = (md_done || md_op == MD_MTHI || md_op == MD_MTLO) ? 2'b00 : wb_ctl_in;
    m_p0  = md_done ? 3'b000 : m_ctl_in;
  end

  // EX/MEM boundary: a stalled cycle launches a bubble.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      wb_ctlout     <= '0;
      m_ctlout      <= '0;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_target <= '0;
      store_data    <= '0;
      wreg          <= '0;
    end else begin
      wb_ctlout     <= wb_p0;
      m_ctlout      <= m_p0;
      alu_result    <= result_p0;
      zero          <= (result_p0 == '0);
      branch_target <= npc_in + (sext_in << 2);
      store_data    <= rdata2_in;
      wreg          <= reg_dst ? rd_in : rt_in;
    end
  end

endmodule
